// File: rtl/fp_sub_issue_buffer.sv
// Issue/capture stage around the fixed-latency FP subtractor: tracks valid/tag through the
// subtractor pipe, captures results with classification flags, and credit-limits issue.
module fp_sub_issue_buffer #(
    parameter int unsigned LATENCY = 13,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [31:0]              sub_a,
    output logic [31:0]              sub_b,
    input  logic [31:0]              sub_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_s,
    output logic [TAG_W-1:0]         out_tag,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   inflight
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 32 + TAG_W + 3;

    logic               fire;
    logic               pop;
    logic               cap;
    logic               empty;
    logic               full;
    logic [LATENCY-1:0] vpipe_q;
    logic [LATENCY-1:0] vpipe_d;
    logic [TAG_W-1:0]   tpipe_q [LATENCY];
    logic [PW:0]        wr_ptr_q;
    logic [PW:0]        wr_ptr_d;
    logic [PW:0]        rd_ptr_q;
    logic [PW:0]        rd_ptr_d;
    logic [CW-1:0]      inflight_q;
    logic [CW-1:0]      inflight_d;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      head;
    logic [7:0]         cap_exp;
    logic [22:0]        cap_mant;
    logic [2:0]         cap_flags;

    // Subtractor runs freely; only cycles with a set valid bit are captured.
    assign sub_a = in_a;
    assign sub_b = in_b;

    // Credit check uses the registered count only, so out_ready never reaches in_ready.
    assign in_ready  = inflight_q < CW'(DEPTH);
    assign fire      = in_valid & in_ready;
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign cap       = vpipe_q[LATENCY-1];
    assign inflight  = inflight_q;

    assign cap_exp   = sub_s[30:23];
    assign cap_mant  = sub_s[22:0];
    assign cap_flags = {(cap_exp == 8'hFF) && (cap_mant != 23'd0),
                        (cap_exp == 8'hFF) && (cap_mant == 23'd0),
                        cap_exp == 8'h00};

    // Head is gated so outputs read zero while the FIFO is empty.
    assign head = mem_q[rd_ptr_q[PW-1:0]];
    assign {out_s, out_tag, out_flags} = out_valid ? head : '0;

    always_comb begin
        vpipe_d    = {vpipe_q[LATENCY-2:0], fire};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        if (cap) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({fire, pop})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vpipe_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                tpipe_q[i] <= '0;
            end
        end else begin
            vpipe_q    <= vpipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            tpipe_q[0] <= in_tag;
            for (int i = 1; i < int'(LATENCY); i++) begin
                tpipe_q[i] <= tpipe_q[i-1];
            end
        end
    end

    // Storage needs no reset: entries are only visible between write and pop.
    always_ff @(posedge clock) begin
        if (cap) begin
            mem_q[wr_ptr_q[PW-1:0]] <= {sub_s, tpipe_q[LATENCY-1], cap_flags};
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(cap && full));
    a_credit_range: assert property (@(posedge clock) disable iff (!reset)
                                     inflight_q <= CW'(DEPTH));

endmodule

// File: doc/fp_sub_issue_buffer.md
Name: fp_sub_issue_buffer

Overview:
Issue and result-capture stage wrapped around the 13-cycle FP subtractor in the sincos datapath. It accepts operand pairs from upstream over valid/ready, drives them onto the subtractor inputs, and tracks each op's valid and tag through the subtractor's fixed latency. It captures each difference into a result FIFO with classification flags and presents it downstream over valid/ready. Credit accounting guarantees no result is ever dropped, even though the subtractor itself has no stall input.

Parameters:
LATENCY, 13, subtractor pipeline depth in cycles (input to io_out_s)
DEPTH, 16, result FIFO entries (power of 2, >= 2)
TAG_W, 4, width of the user tag carried alongside each op

Ports:
clock  in  1  single clock domain
reset  in  1  asynchronous, active-low reset (reset==0 resets the block)
in_valid  in  1  upstream operand pair valid
in_ready  out  1  block can accept an op this cycle
in_a  in  32  IEEE-754 single minuend
in_b  in  32  IEEE-754 single subtrahend
in_tag  in  TAG_W  user tag, returned with result
sub_a  out  32  to subtractor io_in_a
sub_b  out  32  to subtractor io_in_b
sub_s  in  32  from subtractor io_out_s
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_s  out  32  difference a-b
out_tag  out  TAG_W  tag of this result
out_flags  out  3  {nan, inf, zero} of out_s
inflight  out  $clog2(DEPTH)+1  ops issued and not yet popped (debug)

Behaviour:
- fire = in_valid & in_ready; pop = out_valid & out_ready.
- sub_a = in_a, sub_b = in_b combinationally every cycle (subtractor runs freely; non-fire cycles produce ignored results).
- Valid pipe: LATENCY-bit shift register, bit0 <= fire each cycle; parallel tag pipe of LATENCY x TAG_W registers.
- Op fired in cycle t: sub_s carries its result during cycle t+LATENCY; at the end of that cycle, when the pipe's last bit is set, {sub_s, tag, flags} is written into the FIFO. out_valid is asserted earliest in cycle t+LATENCY+1 (total latency 14 at default).
- Flags computed at capture from sub_s: nan = exp==8'hFF & mant!=0; inf = exp==8'hFF & mant==0; zero = exp==0 (flush-to-zero convention; sign ignored).
- Credit counter inflight: +1 on fire, -1 on pop, both in the same cycle leaves it unchanged. Range 0..DEPTH.
- in_ready = (inflight < DEPTH), based on the registered count only. A same-cycle pop does not grant a credit (conservative, avoids combinational out_ready->in_ready path).
- FIFO: circular, rd/wr pointers with wrap bit; write and pop in the same cycle are both performed; capture never hits a full FIFO (guaranteed by credits; add an assertion).
- Outputs out_s/out_tag/out_flags = FIFO head; held stable while out_valid & !out_ready. Results are returned in strict issue order.
- Reset (async assert, sync-safe release): valid pipe, tag pipe, FIFO pointers and inflight cleared. Outputs: out_valid=0, out_s=0, out_tag=0, out_flags=0, inflight=0, in_ready=1. Ops in flight at reset are discarded; results emerging from the subtractor after reset are ignored because their valid bits were cleared.
- in_tag/in_a/in_b may change freely when !fire.

Test Plan:
- Single op: fire in_a=0x40400000, in_b=0x3F800000, tag=5 in cycle 0, out_ready=1 -> out_valid first in cycle 14, out_s=0x40000000, out_tag=5, flags=000; out_valid drops in cycle 15.
- Backpressure fill: out_ready=0, in_valid=1 continuously -> exactly 16 fires, then in_ready=0 and inflight=16. After that, raise out_ready -> 16 results in tag order 0..15, no loss, in_ready returns the cycle after the first pop.
- Flags: a=0x7F800000,b=0x3F800000 -> out_s=0x7F800000, flags=010; a=b=0x3F800000 -> zero flag=1; a=0x7FC00000 -> nan flag=1.
- Streaming: in_valid=1, out_ready=1 for 100 cycles with incrementing tags -> one result per cycle after the 14-cycle fill, inflight steady at 14, in_ready never drops.
- Reset mid-flight: fire 3 ops in cycles 0-2, drive reset=0 in cycle 5 for 1 cycle -> out_valid stays 0 through cycle 30, inflight=0, in_ready=1 immediately.
- Simultaneous at full: inflight=16 with out_ready=1 and in_valid=1 -> pop occurs, no fire that cycle, fire next cycle; FIFO order preserved.
